// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register and a one-entry skid buffer for decode stalls.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble cycle counters.
module fetch_stage #(
  parameter int unsigned        DATA_W   = 16,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] InstrD,
  output logic [DATA_W-1:0] PCPlus1D,
  output logic              ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_cycles
`endif
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    REQ     = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] pcf;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] skid_instr;
  logic [DATA_W-1:0] skid_pcp1;
  logic              skid_full;
  logic              skid_full_nxt;
  logic              xfer;
  logic              accept;
  logic              issue_ok;

  assign pc_inc = pcf + DATA_W'(PC_STEP);
  assign xfer   = imem_req && imem_ready;
  // Only a REQ transfer not killed by a same-cycle redirect carries a usable word.
  assign accept = xfer && (state == REQ) && !redirect_valid;

  always_comb begin
    skid_full_nxt = skid_full;
    if (redirect_valid) begin
      skid_full_nxt = 1'b0;
    end else if (StallD) begin
      if (accept) skid_full_nxt = 1'b1;
    end else begin
      skid_full_nxt = 1'b0;
    end
  end

  assign issue_ok = !StallF && !skid_full_nxt && !redirect_valid;

  // Request FSM; imem_req/imem_addr only change once the current transfer completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pcf       <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        pcf <= redirect_pc;
      end else if (accept) begin
        pcf <= pc_inc;
      end

      case (state)
        BOOT: begin
          state <= IDLE;
        end
        IDLE: begin
          if (issue_ok) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pcf;
          end
        end
        REQ: begin
          if (xfer) begin
            if (issue_ok) begin
              imem_addr <= pc_inc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (xfer) begin
            if (issue_ok) begin
              state     <= REQ;
              imem_addr <= pcf;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Skid buffer catches a word that completes while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full  <= 1'b0;
      skid_instr <= '0;
      skid_pcp1  <= '0;
    end else begin
      skid_full <= skid_full_nxt;
      if (!redirect_valid && StallD && accept) begin
        skid_instr <= imem_rdata;
        skid_pcp1  <= pc_inc;
      end
    end
  end

  // IF/ID register: redirect > stall > skid > new fetch > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= '0;
      PCPlus1D <= '0;
      ValidD   <= 1'b0;
    end else if (redirect_valid) begin
      ValidD <= 1'b0;
    end else if (StallD) begin
      ValidD <= ValidD;
    end else if (skid_full) begin
      InstrD   <= skid_instr;
      PCPlus1D <= skid_pcp1;
      ValidD   <= 1'b1;
    end else if (accept) begin
      InstrD   <= imem_rdata;
      PCPlus1D <= pc_inc;
      ValidD   <= 1'b1;
    end else begin
      ValidD <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if ((StallF || StallD) && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((state != BOOT) && !ValidD && (bubble_cycles != 32'hFFFF_FFFF)) begin
        bubble_cycles <= bubble_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a zero-wait memory model returning addr ^ 16'hA5A5.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        StallD;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] InstrD;
  logic [15:0] PCPlus1D;
  logic        ValidD;
  logic        mem_hold;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;
`endif

  int n_tests;
  int n_fail;

  assign imem_ready = imem_req && !mem_hold;
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .StallF         (StallF),
    .StallD         (StallD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .InstrD         (InstrD),
    .PCPlus1D       (PCPlus1D),
    .ValidD         (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .bubble_cycles  (bubble_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [15:0] instr, input logic [15:0] pcp1);
    check({tag, "_valid"}, 32'(ValidD), 32'd1);
    check({tag, "_instr"}, 32'(InstrD), 32'(instr));
    check({tag, "_pcp1"},  32'(PCPlus1D), 32'(pcp1));
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    StallF         = 1'b0;
    StallD         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    mem_hold       = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  32'(imem_addr), 32'h0000);
    check("rst_valid", 32'(ValidD), 32'd0);
    check("rst_instr", 32'(InstrD), 32'h0000);
    check("rst_pcp1",  32'(PCPlus1D), 32'h0000);
    rst_n = 1'b1;

    // Boot cycle, then back-to-back zero-wait fetch
    tick();
    check("boot_req", 32'(imem_req), 32'd0);
    tick();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'h0000);
    check("first_valid", 32'(ValidD), 32'd0);
    tick();
    check_d("f0", 16'hA5A5, 16'h0001);
    check("addr1", 32'(imem_addr), 32'h0001);
    tick();
    check_d("f1", 16'hA5A4, 16'h0002);
    check("addr2", 32'(imem_addr), 32'h0002);
    tick();
    check_d("f2", 16'hA5A7, 16'h0003);
    check("addr3", 32'(imem_addr), 32'h0003);
    tick();
    tick();
    check_d("f4", 16'hA5A1, 16'h0005);
    check("addr5", 32'(imem_addr), 32'h0005);

    // Wait states at addr 5 with StallF pulsed
    mem_hold = 1'b1;
    StallF   = 1'b1;
    tick();
    StallF = 1'b0;
    check("w_addr0", 32'(imem_addr), 32'h0005);
    check("w_req0",  32'(imem_req), 32'd1);
    check("w_valid0", 32'(ValidD), 32'd0);
    tick();
    check("w_addr1", 32'(imem_addr), 32'h0005);
    tick();
    check("w_addr2", 32'(imem_addr), 32'h0005);
    check("w_req2",  32'(imem_req), 32'd1);
    mem_hold = 1'b0;
    tick();
    check_d("f5", 16'hA5A0, 16'h0006);
    check("addr6", 32'(imem_addr), 32'h0006);
    mem_hold = 1'b1;
    tick();
    check("once_valid", 32'(ValidD), 32'd0);

    // Completion under StallD lands in the skid buffer
    StallD   = 1'b1;
    mem_hold = 1'b0;
    tick();
    check("sd_instr0", 32'(InstrD), 32'hA5A0);
    check("sd_req0",   32'(imem_req), 32'd0);
    tick();
    check("sd_instr1", 32'(InstrD), 32'hA5A0);
    check("sd_req1",   32'(imem_req), 32'd0);
    StallD = 1'b0;
    tick();
    check_d("skid", 16'hA5A3, 16'h0007);
    check("sd_req2",  32'(imem_req), 32'd1);
    check("sd_addr2", 32'(imem_addr), 32'h0007);

    // Redirect during an outstanding wait
    mem_hold = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("disc_req",   32'(imem_req), 32'd1);
    check("disc_addr",  32'(imem_addr), 32'h0007);
    check("disc_valid", 32'(ValidD), 32'd0);
    mem_hold = 1'b0;
    tick();
    check("drop_valid", 32'(ValidD), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'h0040);
    check("redir_req",  32'(imem_req), 32'd1);
    tick();
    check_d("f40", 16'hA5E5, 16'h0041);

    // Redirect coinciding with ready drops the word; then PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    check("rdy_redir_valid", 32'(ValidD), 32'd0);
    check("rdy_redir_req",   32'(imem_req), 32'd0);
    tick();
    check("wrap_addr", 32'(imem_addr), 32'hFFFF);
    tick();
    check_d("wrap", 16'h5A5A, 16'h0000);
    check("wrap_next", 32'(imem_addr), 32'h0000);
    tick();
    check_d("f0b", 16'hA5A5, 16'h0001);

    // Asynchronous reset while a request waits
    mem_hold = 1'b1;
    tick();
    check("pre_rst_addr", 32'(imem_addr), 32'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   32'(imem_req), 32'd0);
    check("arst_addr",  32'(imem_addr), 32'h0000);
    check("arst_valid", 32'(ValidD), 32'd0);
    check("arst_instr", 32'(InstrD), 32'h0000);
    check("arst_pcp1",  32'(PCPlus1D), 32'h0000);
    mem_hold = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("reboot_req", 32'(imem_req), 32'd0);
    tick();
    check("reboot_req1",  32'(imem_req), 32'd1);
    check("reboot_addr1", 32'(imem_addr), 32'h0000);
    tick();
    check_d("rb0", 16'hA5A5, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit, 8-register pipelined core.
- Holds PCF and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Applies StallF/StallD from hazard_detection and redirects from branch/jump resolution.
- Presents InstrD/PCPlus1D/ValidD to decode, where the register fields feed the hazard unit A/B inputs.

Parameters:
- DATA_W, 16, instruction and PC width.
- RESET_PC, 16'h0000, PC loaded at reset.
- PC_STEP, 1, PC increment per instruction (word addressed).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PC; no new request issued.
- StallD  in  1  hold IF/ID contents.
- redirect_valid  in  1  branch/jump taken; flush fetch.
- redirect_pc  in  DATA_W  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  DATA_W  fetch address.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  DATA_W  instruction word.
- InstrD  out  DATA_W  decode-stage instruction.
- PCPlus1D  out  DATA_W  fetch PC + PC_STEP of InstrD.
- ValidD  out  1  InstrD is a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst_n=0):
  - PCF=RESET_PC; state=BOOT; imem_req=0; imem_addr=RESET_PC.
  - InstrD=0, PCPlus1D=0, ValidD=0; skid buffer empty.
- FSM states:
  - BOOT: one idle cycle after reset release, then IDLE.
  - IDLE: no request outstanding. Goes to REQ when !StallF && !skid_full && !redirect_valid.
  - REQ: imem_req=1, imem_addr=PCF.
  - DISCARD: imem_req=1; waits for ready and drops the returned data.
- Handshake:
  - A transfer completes on a cycle with imem_req && imem_ready.
  - Once imem_req is high, it and imem_addr stay stable until ready, regardless of StallF.
  - imem_ready outside REQ/DISCARD is ignored.
- On completion in REQ: PCF += PC_STEP (mod 2^DATA_W; 16'hFFFF wraps to 16'h0000).
  - Next state is REQ if !StallF && skid not becoming full, else IDLE.
  - This gives back-to-back issue, one instruction per cycle with zero-wait memory.
- Redirect (highest priority):
  - PCF<=redirect_pc; skid cleared; ValidD<=0 next cycle, even if StallD=1.
  - If a request is outstanding without ready this cycle, go to DISCARD. The next REQ uses the new PCF after the old transfer completes.
  - If ready arrives in the same cycle as redirect, the data is dropped.
- IF/ID update, in priority order:
  1. redirect_valid: bubble.
  2. StallD: hold. Any completed fetch goes to the skid buffer; a completion while the skid is already full is impossible because issue is blocked when full.
  3. Skid full: load from skid, skid empties.
  4. Completion: load InstrD=imem_rdata, PCPlus1D=PCF+PC_STEP, ValidD=1.
  5. Otherwise: ValidD=0 (bubble). InstrD/PCPlus1D hold their values.
- StallF with !StallD: decode drains; ValidD=0 once no data is available.
- Latency:
  - Zero-wait memory: request at cycle n gives ValidD=1 at n+1.
  - First request is issued 1 cycle after BOOT.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds output stall_cycles [31:0], counting cycles with StallF||StallD.
  - Adds output bubble_cycles [31:0], counting cycles with ValidD=0 after BOOT.
  - Both are saturating, reset to 0, and cleared by a redirect only via reset.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Zero-wait memory returning rdata=addr^16'hA5A5 from reset → imem_addr 0,1,2,3 on consecutive cycles; ValidD=1 from the cycle after the first request; PCPlus1D=1,2,3.
- imem_ready held low 3 cycles at addr 5 with StallF pulsed → imem_addr stays 5, imem_req stays 1; instruction delivered once, PCF=6.
- Completion with StallD=1 for 2 cycles → InstrD unchanged; skid holds the word; no new request; on StallD release InstrD=skid word, ValidD=1, next addr issued.
- redirect_valid with redirect_pc=16'h0040 during an outstanding wait → DISCARD; stale data dropped; ValidD=0; next request addr=16'h0040.
- PCF=16'hFFFF completes → PCF=16'h0000, PCPlus1D=16'h0000.
- rst_n asserted mid-wait → all outputs go to reset values immediately; BOOT cycle precedes the first req at RESET_PC.
